// File: rtl/spi_sram_slave.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM (READ/WRITE/RDSR, sequential mode).
// SPI pins are oversampled in the i_clk domain and drive a byte-wide RAM port.
module spi_sram_slave #(
    parameter int depth = 65536,
    parameter int aw = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sclk,
    input  logic          i_cs_n,
    input  logic          i_mosi,
    output logic          o_miso,
    output logic          o_miso_oe,
    output logic [aw-1:0] o_addr,
    output logic [7:0]    o_wdata,
    output logic          o_we,
    output logic          o_re,
    input  logic [7:0]    i_rdata
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, RD_FETCH, RD_SHIFT,
        WR_SHIFT, WR_STROBE, STATUS, IGNORE
    } state_t;

    localparam logic [7:0] STATUS_VAL = 8'h40;

    state_t state, state_d;
    logic [1:0] sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q;
    logic [3:0] cnt, cnt_d;
    logic [1:0] fcnt, fcnt_d;
    logic [15:0] sh, sh_d, sh_in;
    logic rd, rd_d;
    logic miso_d, oe_d, we_d, re_d;
    logic [aw-1:0] addr_d;
    logic [7:0] wdata_d;
    logic cs_hi, cs_fall, sclk_rise, sclk_fall;

    assign cs_hi = cs_s[1];
    assign cs_fall = cs_q & ~cs_s[1];
    assign sclk_rise = ~cs_hi & sclk_s[1] & ~sclk_q;
    assign sclk_fall = ~cs_hi & ~sclk_s[1] & sclk_q;
    assign sh_in = {sh[14:0], mosi_s[1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_s <= 2'b00;
            cs_s <= 2'b11;
            mosi_s <= 2'b00;
            sclk_q <= 1'b0;
            cs_q <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            fcnt <= '0;
            sh <= '0;
            rd <= 1'b0;
            o_miso <= 1'b0;
            o_miso_oe <= 1'b0;
            o_addr <= '0;
            o_wdata <= '0;
            o_we <= 1'b1;
            o_re <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], i_sclk};
            cs_s <= {cs_s[0], i_cs_n};
            mosi_s <= {mosi_s[0], i_mosi};
            sclk_q <= sclk_s[1];
            cs_q <= cs_s[1];
            state <= state_d;
            cnt <= cnt_d;
            fcnt <= fcnt_d;
            sh <= sh_d;
            rd <= rd_d;
            o_miso <= miso_d;
            o_miso_oe <= oe_d;
            o_addr <= addr_d;
            o_wdata <= wdata_d;
            o_we <= we_d;
            o_re <= re_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        fcnt_d = fcnt;
        sh_d = sh;
        rd_d = rd;
        miso_d = o_miso;
        oe_d = o_miso_oe;
        addr_d = o_addr;
        wdata_d = o_wdata;
        we_d = o_we;
        re_d = 1'b0;
        // A running write strobe always finishes before deselect takes effect
        if (cs_hi && state != WR_STROBE) begin
            state_d = IDLE;
            oe_d = 1'b0;
            cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d = '0;
                        sh_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        sh_d = sh_in;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d = '0;
                            case (sh_in[7:0])
                                8'h03: begin
                                    state_d = ADDR;
                                    rd_d = 1'b1;
                                end
                                8'h02: begin
                                    state_d = ADDR;
                                    rd_d = 1'b0;
                                end
                                8'h05: begin
                                    state_d = STATUS;
                                    sh_d = {8'h00, STATUS_VAL};
                                    miso_d = STATUS_VAL[7];
                                    oe_d = 1'b1;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        sh_d = sh_in;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            cnt_d = '0;
                            addr_d = sh_in[aw-1:0];
                            if (rd) begin
                                state_d = RD_FETCH;
                                re_d = 1'b1;
                                fcnt_d = '0;
                            end else begin
                                state_d = WR_SHIFT;
                            end
                        end
                    end
                end
                RD_FETCH: begin
                    fcnt_d = fcnt + 2'd1;
                    if (fcnt == 2'd2) begin
                        state_d = RD_SHIFT;
                        sh_d = {8'h00, i_rdata};
                        miso_d = i_rdata[7];
                        oe_d = 1'b1;
                        cnt_d = '0;
                    end
                end
                RD_SHIFT, STATUS: begin
                    if (sclk_rise) begin
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d = '0;
                            if (state == RD_SHIFT) begin
                                state_d = RD_FETCH;
                                addr_d = o_addr + aw'(1);
                                re_d = 1'b1;
                                fcnt_d = '0;
                            end else begin
                                sh_d = {8'h00, STATUS_VAL};
                                miso_d = STATUS_VAL[7];
                            end
                        end
                    end else if (sclk_fall && cnt != 4'd0) begin
                        // bit7 of each byte was already presented by the load
                        miso_d = sh[6];
                        sh_d = {8'h00, sh[6:0], 1'b0};
                    end
                end
                WR_SHIFT: begin
                    if (sclk_rise) begin
                        sh_d = sh_in;
                        cnt_d = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_d = '0;
                            wdata_d = sh_in[7:0];
                            we_d = 1'b0;
                            fcnt_d = '0;
                            state_d = WR_STROBE;
                        end
                    end
                end
                WR_STROBE: begin
                    fcnt_d = fcnt + 2'd1;
                    if (fcnt == 2'd1) begin
                        we_d = 1'b1;
                    end
                    if (fcnt == 2'd2) begin
                        addr_d = o_addr + aw'(1);
                        fcnt_d = '0;
                        cnt_d = '0;
                        state_d = cs_hi ? IDLE : WR_SHIFT;
                    end
                end
                IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_slave.sv
// Bench for spi_sram_slave: SPI master driver, byte-wide RAM model and a
// transaction-level reference memory used to predict strobes and read data.
module tb_spi_sram_slave;

    logic clk = 1'b0;
    logic rst;
    logic sclk, cs_n, mosi;
    logic miso, miso_oe;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic we, re;
    logic [7:0] rdata = 8'h00;

    always #5 clk = ~clk;

    spi_sram_slave dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sclk(sclk),
        .i_cs_n(cs_n),
        .i_mosi(mosi),
        .o_miso(miso),
        .o_miso_oe(miso_oe),
        .o_addr(addr),
        .o_wdata(wdata),
        .o_we(we),
        .o_re(re),
        .i_rdata(rdata)
    );

    // RAM model: read data valid two cycles after the read strobe
    logic [7:0] mem [0:65535];
    logic [7:0] rd_p1 = 8'h00;
    always @(posedge clk) begin
        if (!we) mem[addr] <= wdata;
        if (re) rd_p1 <= mem[addr];
        rdata <= rd_p1;
    end

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] ref_mem [0:65535];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor
    logic we_d1 = 1'b1;
    int low_n = 0;
    int overlap = 0;
    int unstable = 0;
    logic [15:0] s_addr = '0;
    logic [7:0] s_data = '0;
    logic [15:0] wq_addr [$];
    logic [7:0] wq_data [$];
    int wq_len [$];
    logic [15:0] re_q [$];

    always @(negedge clk) begin
        if (re && !we) overlap++;
        if (re) re_q.push_back(addr);
        if (!we) begin
            if (we_d1) begin
                low_n = 0;
                s_addr = addr;
                s_data = wdata;
            end
            low_n++;
            if (addr != s_addr || wdata != s_data) unstable++;
        end else if (!we_d1) begin
            if (addr != s_addr || wdata != s_data) unstable++;
            wq_addr.push_back(s_addr);
            wq_data.push_back(s_data);
            wq_len.push_back(low_n);
        end
        we_d1 = we;
    end

    logic [7:0] wbuf [8];
    logic [7:0] rx, oem;

    task automatic spi_bits(input logic [7:0] tx, input int nb,
                            output logic [7:0] r, output logic [7:0] o);
        r = '0;
        o = '0;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            repeat (6) @(negedge clk);
            sclk = 1'b1;
            r[7-i] = miso;
            o[7-i] = miso_oe;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic write_txn(input logic [15:0] a, input int n);
        logic [7:0] r, o;
        wq_addr.delete();
        wq_data.delete();
        wq_len.delete();
        cs_low();
        spi_bits(8'h02, 8, r, o);
        spi_bits(a[15:8], 8, r, o);
        spi_bits(a[7:0], 8, r, o);
        for (int i = 0; i < n; i++) begin
            spi_bits(wbuf[i], 8, r, o);
            ref_mem[16'(a + i)] = wbuf[i];
        end
        cs_high();
        check("wr_count", wq_addr.size(), n);
        for (int i = 0; i < wq_addr.size() && i < n; i++) begin
            check("wr_addr", wq_addr[i], 16'(a + i));
            check("wr_data", wq_data[i], wbuf[i]);
            check("wr_len", wq_len[i], 2);
        end
        wq_addr.delete();
        wq_data.delete();
        wq_len.delete();
    endtask

    task automatic read_txn(input logic [15:0] a, input int n);
        logic [7:0] r, o, hdr_oe;
        cs_low();
        spi_bits(8'h03, 8, r, o);
        hdr_oe = o;
        spi_bits(a[15:8], 8, r, o);
        hdr_oe |= o;
        spi_bits(a[7:0], 8, r, o);
        hdr_oe |= o;
        check("rd_hdr_oe", hdr_oe, 8'h00);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, r, o);
            check("rd_data", r, ref_mem[16'(a + i)]);
            check("rd_oe", o, 8'hFF);
        end
        cs_high();
        check("rd_oe_end", miso_oe, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        int rn;
        rst = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_addr", addr, 16'h0000);
        check("rst_wdata", wdata, 8'h00);
        check("rst_we", we, 1'b1);
        check("rst_re", re, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h5A;
        write_txn(16'h0010, 2);
        read_txn(16'h0010, 2);

        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        write_txn(16'hFFFF, 2);
        re_q.delete();
        read_txn(16'hFFFF, 2);
        check("wrap_re_cnt", 32'(re_q.size() >= 2), 1);
        if (re_q.size() >= 2) begin
            check("wrap_re0", re_q[0], 16'hFFFF);
            check("wrap_re1", re_q[1], 16'h0000);
        end

        wbuf[0] = 8'h77;
        write_txn(16'h0020, 1);
        cs_low();
        spi_bits(8'h02, 8, rx, oem);
        spi_bits(8'h00, 8, rx, oem);
        spi_bits(8'h20, 8, rx, oem);
        spi_bits(8'hC3, 5, rx, oem);
        cs_high();
        check("abort_wr", wq_addr.size(), 0);
        check("abort_we", we, 1'b1);
        check("abort_oe", miso_oe, 1'b0);
        read_txn(16'h0020, 1);

        re_q.delete();
        cs_low();
        spi_bits(8'h9F, 8, rx, oem);
        spi_bits(8'h00, 8, rx, oem);
        check("unk_oe0", oem, 8'h00);
        spi_bits(8'h00, 8, rx, oem);
        check("unk_oe1", oem, 8'h00);
        cs_high();
        check("unk_re", re_q.size(), 0);
        check("unk_we", wq_addr.size(), 0);

        cs_low();
        spi_bits(8'h05, 8, rx, oem);
        for (int i = 0; i < 2; i++) begin
            spi_bits(8'h00, 8, rx, oem);
            check("status", rx, 8'h40);
            check("status_oe", oem, 8'hFF);
        end
        cs_high();
        check("status_oe_end", miso_oe, 1'b0);

        cs_low();
        spi_bits(8'h03, 8, rx, oem);
        spi_bits(8'h00, 8, rx, oem);
        spi_bits(8'h00, 4, rx, oem);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso", miso, 1'b0);
        check("mid_rst_oe", miso_oe, 1'b0);
        check("mid_rst_addr", addr, 16'h0000);
        check("mid_rst_wdata", wdata, 8'h00);
        check("mid_rst_we", we, 1'b1);
        check("mid_rst_re", re, 1'b0);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        read_txn(16'h0010, 2);

        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom_range(0, 65535));
            if (k == 0) ra = 16'hFFFE;
            rn = $urandom_range(1, 3);
            for (int i = 0; i < rn; i++) wbuf[i] = 8'($urandom);
            write_txn(ra, rn);
            read_txn(ra, rn);
        end

        check("re_we_overlap", overlap, 0);
        check("strobe_stable", unstable, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sram_slave.md
Name: spi_sram_slave

Overview:
- SPI slave front-end that decodes serial SRAM commands and drives the byte-wide port of the RAM model (addr / wdata / active-low write / read strobe / rdata).
- Emulates a 23LC-style serial SRAM in sequential mode: READ 0x03, WRITE 0x02, RDSR 0x05.
- SPI pins (mode 0, MSB first) are oversampled in the i_clk domain.
- It is the stage directly upstream of the RAM in the test harness.

Parameters:
- depth, 65536: RAM size in bytes; must be a power of 2 and at most 65536.
- aw, $clog2(depth): RAM address width.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sclk  in  1  SPI clock (mode 0); asynchronous to i_clk.
- i_cs_n  in  1  SPI chip select, active-low; asynchronous.
- i_mosi  in  1  SPI data in; asynchronous.
- o_miso  out  1  SPI data out.
- o_miso_oe  out  1  MISO output enable; 1 only while driving read or status data.
- o_addr  out  aw  RAM byte address.
- o_wdata  out  8  RAM write data.
- o_we  out  1  RAM write strobe, active-low; idles high.
- o_re  out  1  RAM read strobe, active-high, one-cycle pulse.
- i_rdata  in  8  RAM read data; valid 2 i_clk cycles after o_re.

Behaviour:
- Reset values: o_miso=0, o_miso_oe=0, o_addr=0, o_wdata=0, o_we=1, o_re=0. State is IDLE, all shift registers and bit counters are cleared, and the synchronizers are cleared to sclk=0, cs_n=1.
- Synchronizing: i_sclk, i_cs_n and i_mosi each pass through 2-flop synchronizers. Edge detect runs on the synchronized sclk.
- Clock ratio: i_sclk frequency is at most i_clk/8 (high and low phases each at least 4 i_clk). Faster SCLK is out of contract.
- MOSI sampling: MOSI is sampled on the detected sclk rising edge.
- MISO update: MISO is updated on the detected sclk falling edge, or on the load event for the first bit of a byte.
- States:
  - IDLE: falling edge of cs_n -> CMD, bit count = 0.
  - CMD: shift 8 bits. 0x03 -> ADDR(rd), 0x02 -> ADDR(wr), 0x05 -> STATUS, any other value -> IGNORE.
  - ADDR: shift 16 bits, MSB first. o_addr takes the low aw bits; upper bits are ignored.
    - Read: on the 16th bit go to RD_FETCH.
    - Write: on the 16th bit go to WR_SHIFT.
  - RD_FETCH:
    - o_re pulses 1 cycle with o_addr stable.
    - 2 cycles later, i_rdata loads the shift register; bit7 goes to o_miso and o_miso_oe=1.
    - -> RD_SHIFT.
    - Total latency from the 24th sclk rising edge to valid MISO is 3 i_clk cycles, well before the next falling edge.
  - RD_SHIFT:
    - Each sclk falling edge presents the next bit.
    - On the rising edge of bit 0 of a byte: o_addr increments, then -> RD_FETCH for the next byte. The new byte is loaded before the next falling edge.
  - WR_SHIFT: after 8 rising edges, o_wdata = assembled byte, -> WR_STROBE.
  - WR_STROBE:
    - o_we is held low for exactly 2 i_clk cycles, with o_addr and o_wdata stable throughout and for 1 cycle after o_we rises.
    - Then o_addr increments and the block returns to WR_SHIFT.
    - The strobe completes within 4 cycles, before the next byte's first rising edge.
  - STATUS: shift out the constant 0x40 (sequential mode) MSB first. It repeats for every further 8 clocks.
  - IGNORE: MISO stays tri-state (oe=0), no RAM strobes, wait for cs_n high.
- Address increment: modulo 2^aw. depth-1 wraps to 0 for both read and write.
- Rising edge of cs_n in any state -> IDLE, effective the next cycle. This covers:
  - o_miso_oe forced to 0 and o_re cleared;
  - partial command, address or data byte discarded (no write strobe issued);
  - an in-progress WR_STROBE always completes its 2 cycles first, then -> IDLE;
  - o_addr keeps its last value.
- An SCLK edge seen while synchronized cs_n is high is ignored.
- i_rst asserted mid-transfer behaves as reset. An in-flight strobe is cut: o_we returns to 1 on the next cycle.
- o_re and o_we are never active in the same cycle.

Test Plan:
- Write then read: CS low; send 0x02, 0x0010, 0xA5, 0x5A; CS high.
  - Required: exactly 2 write strobes, each o_we low for 2 cycles, at addr 0x0010/0xA5 and 0x0011/0x5A.
  - Then send 0x03, 0x0010 and clock 16 bits. Required: MISO returns 0xA5 then 0x5A; o_miso_oe is 1 only during data bits.
- Wrap-around: write 0x11 at 0xFFFF and 0x22 at 0x0000 as one sequential write starting at 0xFFFF.
  - Read from 0xFFFF for 2 bytes. Required: 0x11, 0x22; o_addr sequence FFFF -> 0000.
- CS abort: WRITE 0x0020 then 5 data bits, CS high. Required: no o_we low pulse and state IDLE.
  - A subsequent READ 0x0020 returns the preloaded value unchanged.
- Unknown and status commands:
  - Command 0x9F followed by 16 clocks: o_miso_oe stays 0; no o_re or o_we.
  - Command 0x05 followed by 16 clocks: MISO = 0x40, 0x40.
- Reset mid-transfer: assert i_rst during the second address byte of a READ.
  - Required: all outputs at reset values on the next cycle.
  - A new READ after reset release works normally.
